// File: rtl/rram_op_sequencer.sv
// rtl/rram_op_sequencer.sv - RRAM crossbar operation sequencer (write, read, MAC)
module rram_op_sequencer #(
    parameter int ARRAY_SIZE = 16,
    parameter int ADDR_W     = 4,
    parameter int WL_GROUP   = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  ins_valid,
    input  logic [31:0]           ins_data,
    output logic                  ins_ready,
    output logic [ARRAY_SIZE-1:0] wl_en,
    output logic [ARRAY_SIZE-1:0] bl_sel,
    output logic                  sl_en,
    output logic [1:0]            bl_mode,
    output logic [1:0]            v_sel,
    output logic                  pre,
    output logic                  saen,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, PRECH, SENSE, DONE} state_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_SET   = 2'b10;
    localparam logic [1:0] MODE_RESET = 2'b11;

    state_t            state;
    logic [7:0]        t_mult;
    logic [7:0]        pulse_cnt;
    logic              pol;
    logic [ADDR_W-1:0] cur_row;
    logic [ADDR_W-1:0] row_end;

    function automatic logic [ARRAY_SIZE-1:0] span(input int lo, input int hi);
        logic [ARRAY_SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < ARRAY_SIZE; i++)
            if (i >= lo && i <= hi) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    logic [3:0]        opc;
    logic [ADDR_W-1:0] f0, f1, f2, f3;
    logic              cell_ok, mac_ok, last_grp;
    int                first_hi, grp_hi, nxt_lo, nxt_hi;
    logic              unused_ins;

    assign unused_ins = ^ins_data;

    // f0/f1 are col/row for WRITE/READ and col_start/col_end for MAC; f2/f3 are MAC row_start/row_end
    always_comb begin
        opc      = ins_data[31:28];
        f0       = ins_data[ADDR_W-1:0];
        f1       = ins_data[ADDR_W+7:8];
        f2       = ins_data[ADDR_W+15:16];
        f3       = ins_data[ADDR_W+23:24];
        cell_ok  = (int'(f0) < ARRAY_SIZE) && (int'(f1) < ARRAY_SIZE);
        mac_ok   = cell_ok && (int'(f2) < ARRAY_SIZE) && (int'(f3) < ARRAY_SIZE)
                   && (f1 >= f0) && (f3 >= f2);
        first_hi = min_i(int'(f2) + WL_GROUP - 1, int'(f3));
        grp_hi   = min_i(int'(cur_row) + WL_GROUP - 1, int'(row_end));
        last_grp = grp_hi >= int'(row_end);
        nxt_lo   = grp_hi + 1;
        nxt_hi   = min_i(nxt_lo + WL_GROUP - 1, int'(row_end));
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            t_mult    <= '0;
            v_sel     <= '0;
            pulse_cnt <= '0;
            pol       <= 1'b0;
            cur_row   <= '0;
            row_end   <= '0;
            ins_ready <= 1'b1;
            wl_en     <= '0;
            bl_sel    <= '0;
            sl_en     <= 1'b0;
            bl_mode   <= MODE_IDLE;
            pre       <= 1'b0;
            saen      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (ins_valid) begin
                    case (opc)
                        4'd1: if (cell_ok) begin
                            state     <= SETUP;
                            ins_ready <= 1'b0;
                            busy      <= 1'b1;
                            pol       <= ins_data[16];
                            wl_en     <= span(int'(f1), int'(f1));
                            bl_sel    <= span(int'(f0), int'(f0));
                            sl_en     <= 1'b1;
                        end else err <= 1'b1;
                        // a single-cell READ is a one-group MAC over one row and one column
                        4'd2: if (cell_ok) begin
                            state     <= PRECH;
                            ins_ready <= 1'b0;
                            busy      <= 1'b1;
                            cur_row   <= f1;
                            row_end   <= f1;
                            wl_en     <= span(int'(f1), int'(f1));
                            bl_sel    <= span(int'(f0), int'(f0));
                            bl_mode   <= MODE_READ;
                            pre       <= 1'b1;
                        end else err <= 1'b1;
                        4'd3: if (mac_ok) begin
                            state     <= PRECH;
                            ins_ready <= 1'b0;
                            busy      <= 1'b1;
                            cur_row   <= f2;
                            row_end   <= f3;
                            wl_en     <= span(int'(f2), first_hi);
                            bl_sel    <= span(int'(f0), int'(f1));
                            bl_mode   <= MODE_READ;
                            pre       <= 1'b1;
                        end else err <= 1'b1;
                        4'd4: begin
                            t_mult <= ins_data[7:0];
                            done   <= 1'b1;
                        end
                        4'd5: begin
                            v_sel <= ins_data[1:0];
                            done  <= 1'b1;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                SETUP: begin
                    state     <= PULSE;
                    pulse_cnt <= t_mult;
                    bl_mode   <= pol ? MODE_RESET : MODE_SET;
                end
                PULSE: if (pulse_cnt == 8'd0) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    wl_en   <= '0;
                    bl_sel  <= '0;
                    sl_en   <= 1'b0;
                    bl_mode <= MODE_IDLE;
                end else begin
                    pulse_cnt <= pulse_cnt - 8'd1;
                end
                PRECH: begin
                    state <= SENSE;
                    pre   <= 1'b0;
                    saen  <= 1'b1;
                end
                SENSE: if (last_grp) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    wl_en   <= '0;
                    bl_sel  <= '0;
                    bl_mode <= MODE_IDLE;
                    saen    <= 1'b0;
                end else begin
                    state   <= PRECH;
                    cur_row <= nxt_lo[ADDR_W-1:0];
                    wl_en   <= span(nxt_lo, nxt_hi);
                    pre     <= 1'b1;
                    saen    <= 1'b0;
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    ins_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rram_op_sequencer.sv
// tb/tb_rram_op_sequencer.sv - self-checking bench for rram_op_sequencer
module tb_rram_op_sequencer;
    localparam int N = 16;
    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_valid = 1'b0;
    logic [31:0] ins_data = 32'h0;
    logic        ins_ready, sl_en, pre, saen, busy, done, err;
    logic [15:0] wl_en, bl_sel;
    logic [1:0]  bl_mode, v_sel;

    rram_op_sequencer #(.ARRAY_SIZE(N), .ADDR_W(4), .WL_GROUP(G)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .ins_valid(ins_valid), .ins_data(ins_data),
        .ins_ready(ins_ready), .wl_en(wl_en), .bl_sel(bl_sel), .sl_en(sl_en),
        .bl_mode(bl_mode), .v_sel(v_sel), .pre(pre), .saen(saen),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready, busy, done, err;
        logic [15:0] wl, bl;
        logic        sl;
        logic [1:0]  mode, vsel;
        logic        pre, saen;
    } rec_t;

    rec_t       expq[$];
    int         m_t = 0;
    logic [1:0] m_v = 2'b00;
    int         total = 0;
    int         bad = 0;

    function automatic logic [15:0] rows(input int lo, input int hi);
        int m;
        m = ((1 << (hi + 1)) - 1) & ~((1 << lo) - 1);
        return m[15:0];
    endfunction

    function automatic rec_t line(input logic b, input logic d, input logic e,
                                  input logic [15:0] wl, input logic [15:0] bl,
                                  input logic sl, input logic [1:0] mode,
                                  input logic p, input logic s);
        rec_t r;
        r.ready = ~b; r.busy = b; r.done = d; r.err = e;
        r.wl = wl; r.bl = bl; r.sl = sl; r.mode = mode;
        r.vsel = m_v; r.pre = p; r.saen = s;
        return r;
    endfunction

    // Expected cycle-by-cycle output trace following acceptance of instruction w
    task automatic push_trace(input logic [31:0] w);
        int op, c, r, rs, re, hi;
        op = int'(w[31:28]);
        c  = int'(w[3:0]);
        r  = int'(w[11:8]);
        rs = int'(w[19:16]);
        re = int'(w[27:24]);
        case (op)
            1: if (c < N && r < N) begin
                expq.push_back(line(1'b1, 1'b0, 1'b0, rows(r, r), rows(c, c), 1'b1, 2'b00, 1'b0, 1'b0));
                for (int k = 0; k <= m_t; k++)
                    expq.push_back(line(1'b1, 1'b0, 1'b0, rows(r, r), rows(c, c), 1'b1,
                                        w[16] ? 2'b11 : 2'b10, 1'b0, 1'b0));
                expq.push_back(line(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            end else expq.push_back(line(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            2: if (c < N && r < N) begin
                expq.push_back(line(1'b1, 1'b0, 1'b0, rows(r, r), rows(c, c), 1'b0, 2'b01, 1'b1, 1'b0));
                expq.push_back(line(1'b1, 1'b0, 1'b0, rows(r, r), rows(c, c), 1'b0, 2'b01, 1'b0, 1'b1));
                expq.push_back(line(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            end else expq.push_back(line(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            3: if (c < N && r < N && rs < N && re < N && r >= c && re >= rs) begin
                for (int lo = rs; lo <= re; lo += G) begin
                    hi = (lo + G - 1 < re) ? lo + G - 1 : re;
                    expq.push_back(line(1'b1, 1'b0, 1'b0, rows(lo, hi), rows(c, r), 1'b0, 2'b01, 1'b1, 1'b0));
                    expq.push_back(line(1'b1, 1'b0, 1'b0, rows(lo, hi), rows(c, r), 1'b0, 2'b01, 1'b0, 1'b1));
                end
                expq.push_back(line(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            end else expq.push_back(line(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            4: begin
                m_t = int'(w[7:0]);
                expq.push_back(line(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            end
            5: begin
                m_v = w[1:0];
                expq.push_back(line(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
            end
            default: expq.push_back(line(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0));
        endcase
    endtask

    always @(negedge clk) begin
        rec_t a, e;
        a.ready = ins_ready; a.busy = busy; a.done = done; a.err = err;
        a.wl = wl_en; a.bl = bl_sel; a.sl = sl_en; a.mode = bl_mode;
        a.vsel = v_sel; a.pre = pre; a.saen = saen;
        if (rst) begin
            expq.delete();
            m_t = 0;
            m_v = 2'b00;
        end
        if (!rst && expq.size() > 0) e = expq.pop_front();
        else e = line(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL cycle @%0t: got %h want %h", $time, a, e);
        end
        if (!rst && ins_valid && e.ready) push_trace(ins_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Presents w until accepted; n = cycles sampled before acceptance, t = accepting edge time
    task automatic send(input logic [31:0] w, output int n, output longint t);
        logic rdy;
        @(posedge clk); #1;
        ins_valid = 1'b1;
        ins_data  = w;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = ins_ready;
            n++;
            @(posedge clk); #1;
        end
        t = $time - 1;
        ins_valid = 1'b0;
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        longint tw, tr;
        #12;
        chk("rst_ready", 32'(ins_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lines", 32'({wl_en, bl_sel}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        send(32'h40000003, n, tw);
        @(negedge clk);
        chk("conf_t_done", 32'(done), 32'd1);
        chk("conf_t_busy", 32'(busy), 32'd0);

        send(32'h10010302, n, tw);
        @(negedge clk);
        chk("wr_setup_wl", 32'(wl_en), 32'h0008);
        chk("wr_setup_bl", 32'(bl_sel), 32'h0004);
        chk("wr_setup_mode", 32'(bl_mode), 32'd0);
        k = 0;
        n = 1;
        do begin
            @(negedge clk);
            n++;
            if (bl_mode == 2'b11) k++;
        end while (!done && n < 50);
        chk("wr_pulse_cycles", 32'(k), 32'd4);
        chk("wr_done_cycle", 32'(n), 32'd6);

        send(32'h20000A0C, n, tw);
        @(negedge clk);
        chk("rd_prech_pre", 32'(pre), 32'd1);
        chk("rd_prech_wl", 32'(wl_en), 32'h0400);
        chk("rd_prech_bl", 32'(bl_sel), 32'h1000);
        @(negedge clk);
        chk("rd_sense", 32'({saen, pre}), 32'b10);
        @(negedge clk);
        chk("rd_done_c3", 32'(done), 32'd1);

        send(32'h3A000003, n, tw);
        @(negedge clk);
        chk("mac_bad_err", 32'(err), 32'd1);
        chk("mac_bad_quiet", 32'({done, busy, wl_en, bl_sel}), 32'd0);

        send(32'h3A020F00, n, tw);
        @(negedge clk);
        chk("mac_bl", 32'(bl_sel), 32'hFFFF);
        chk("mac_wl0", 32'(wl_en), 32'h003C);
        @(negedge clk);
        @(negedge clk);
        chk("mac_wl1", 32'(wl_en), 32'h03C0);
        @(negedge clk);
        @(negedge clk);
        chk("mac_wl2", 32'(wl_en), 32'h0400);
        wait_done(n);
        chk("mac_done_cycle", 32'(n + 5), 32'd7);

        send(32'hF0000000, n, tw);
        @(negedge clk);
        chk("op_f_err", 32'({err, done}), 32'b10);

        send(32'h10000101, n, tw);
        send(32'h20000203, n, tr);
        chk("held_read_accept", 32'((tr - tw) / 10), 32'd7);
        wait_done(n);
        chk("held_read_done", 32'(n), 32'd3);

        send(32'h50000002, n, tw);
        @(negedge clk);
        chk("conf_v_sel", 32'(v_sel), 32'd2);

        send(32'h10000305, n, tw);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_pulse", 32'(bl_mode), 32'b10);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_lines", 32'({wl_en, bl_sel}), 32'd0);
        chk("async_rst_mode", 32'({bl_mode, v_sel, done}), 32'd0);
        chk("async_rst_ready", 32'({ins_ready, busy}), 32'b10);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        send(32'h10000101, n, tw);
        chk("first_accept", 32'(n), 32'd1);
        wait_done(n);
        chk("wr_t0_latency", 32'(n), 32'd3);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
